// File: rtl/register_bank.sv
// Sixteen-entry architectural register file with dedicated link (R14) and PC (R15) load paths.
// Outputs come straight from the flops; read selection happens downstream.
module register_bank #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [3:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              bl_we,
  input  logic [DATA_W-1:0] lr_data,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [DATA_W-1:0] r4,
  output logic [DATA_W-1:0] r5,
  output logic [DATA_W-1:0] r6,
  output logic [DATA_W-1:0] r7,
  output logic [DATA_W-1:0] r8,
  output logic [DATA_W-1:0] r9,
  output logic [DATA_W-1:0] r10,
  output logic [DATA_W-1:0] r11,
  output logic [DATA_W-1:0] r12,
  output logic [DATA_W-1:0] r13,
  output logic [DATA_W-1:0] r14,
  output logic [DATA_W-1:0] r15
);

  logic [NREG-1:0][DATA_W-1:0] regs;

  // The link write is ordered after the general write so it wins any collision on R14.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      regs[15] <= pc_in;
      if (we && (wa != 4'd15))
        regs[wa] <= wd;
      if (bl_we)
        regs[14] <= lr_data;
    end
  end

  assign r0  = regs[0];
  assign r1  = regs[1];
  assign r2  = regs[2];
  assign r3  = regs[3];
  assign r4  = regs[4];
  assign r5  = regs[5];
  assign r6  = regs[6];
  assign r7  = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];
  assign r15 = regs[15];

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: vector table plus reference model feeding a scoreboard queue,
// with hand-written sequences for asynchronous reset behaviour.
module tb_register_bank;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [3:0]    wa;
  logic [DW-1:0] wd;
  logic          bl_we;
  logic [DW-1:0] lr_data;
  logic [DW-1:0] pc_in;
  logic [DW-1:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [DW-1:0] r8, r9, r10, r11, r12, r13, r14, r15;

  register_bank #(.DATA_W(DW), .NREG(16)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .bl_we(bl_we), .lr_data(lr_data), .pc_in(pc_in),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15)
  );

  always #5 clk = ~clk;

  typedef logic [15:0][DW-1:0] bank_t;

  typedef struct {
    logic          we;
    logic [3:0]    wa;
    logic [DW-1:0] wd;
    logic          bl_we;
    logic [DW-1:0] lr_data;
    logic [DW-1:0] pc_in;
    int            chk_idx;
    logic [DW-1:0] chk_val;
  } vec_t;

  bank_t mdl;
  bank_t exp_q[$];
  bank_t dut_bank;
  int    checks = 0;
  int    failures = 0;
  vec_t  vecs[8];

  assign dut_bank = {r15, r14, r13, r12, r11, r10, r9, r8, r7, r6, r5, r4, r3, r2, r1, r0};

  task automatic compareOne(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic compareBank(input string tag, input bank_t expv);
    for (int i = 0; i < 16; i++)
      compareOne($sformatf("%s_r%0d", tag, i), dut_bank[i], expv[i]);
  endtask

  task automatic checkOutput(input string tag);
    bank_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s scoreboard_empty got=0 entries expected=1", tag);
    end else begin
      e = exp_q.pop_front();
      compareBank(tag, e);
    end
  endtask

  // Called just after a falling edge: drives one cycle, confirms no write-through, then checks after the rising edge.
  task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [DW-1:0] d,
                               input logic bl, input logic [DW-1:0] lr, input logic [DW-1:0] pc,
                               input string tag);
    bank_t nxt;
    we = w; wa = a; wd = d; bl_we = bl; lr_data = lr; pc_in = pc;
    nxt = mdl;
    nxt[15] = pc;
    if (w === 1'b1 && a != 4'd15) nxt[a] = d;
    if (bl === 1'b1) nxt[14] = lr;
    exp_q.push_back(nxt);
    #1;
    compareBank({tag, "_pre"}, mdl);
    @(posedge clk);
    #1;
    mdl = nxt;
    checkOutput(tag);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 32'h0,        32'h00000100, 3,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 4'd15, 32'h12345678, 1'b0, 32'h0,        32'h00000108, 15, 32'h00000108};
    vecs[2] = '{1'b1, 4'd14, 32'hFFFFFFFF, 1'b1, 32'h00000040, 32'h00000110, 14, 32'h00000040};
    vecs[3] = '{1'b1, 4'd2,  32'h00000007, 1'b1, 32'h00000044, 32'h00000118, 14, 32'h00000044};
    vecs[4] = '{1'b0, 4'bxxxx, {DW{1'bx}}, 1'b0, 32'h0,        32'h00000120, 3,  32'hDEADBEEF};
    vecs[5] = '{1'b1, 4'd0,  32'hA5A5A5A5, 1'b0, 32'h0,        32'h00000128, 0,  32'hA5A5A5A5};
    vecs[6] = '{1'b0, 4'd9,  32'h99999999, 1'b1, 32'h00000080, 32'h00000130, 9,  32'h00000000};
    vecs[7] = '{1'b1, 4'd14, 32'h00001111, 1'b0, 32'h0,        32'h00000138, 14, 32'h00001111};

    rst_n = 1'b0;
    we = 1'b0; wa = 4'd0; wd = '0; bl_we = 1'b0; lr_data = '0; pc_in = 32'h0000_0055;
    mdl = '0;
    #2;
    compareBank("reset", '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].bl_we, vecs[v].lr_data,
                    vecs[v].pc_in, $sformatf("vec%0d", v));
      compareOne($sformatf("vec%0d_spec", v), dut_bank[vecs[v].chk_idx], vecs[v].chk_val);
    end
    compareOne("dual_write_r2", r2, 32'h00000007);

    for (int i = 0; i < 15; i++)
      applyStimulus(1'b1, 4'(i), 32'hC000_0000 + 32'(i), 1'b0, '0, 32'h0000_0200 + 32'(i),
                    $sformatf("fill%0d", i));

    we = 1'b1; wa = 4'd5; wd = 32'h0000_0BAD; bl_we = 1'b1; lr_data = 32'h0000_0BAD; pc_in = 32'h0000_0300;
    #2;
    rst_n = 1'b0;
    mdl = '0;
    #1;
    compareBank("async_rst", '0);
    @(posedge clk);
    #1;
    compareBank("rst_edge", '0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd5, 32'h0000_0077, 1'b0, '0, 32'h0000_0308, "post_rst");
    compareOne("post_rst_r5", r5, 32'h0000_0077);
    compareOne("post_rst_r15", r15, 32'h0000_0308);
    compareOne("post_rst_r14", r14, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter: DATA_W, 32, width of every register and data port.
REQ-002 Parameter: NREG, 16, number of architectural registers R0..R15; fixed at 16 because the 4-bit address space covers exactly R0..R15.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 Port: we  input  1  general write enable.
REQ-006 Port: wa  input  4  general write address (register index 0..15).
REQ-007 Port: wd  input  DATA_W  general write data.
REQ-008 Port: bl_we  input  1  link write enable (branch-with-link); targets R14.
REQ-009 Port: lr_data  input  DATA_W  link data written to R14.
REQ-010 Port: pc_in  input  DATA_W  program-counter-derived value (PC+8) loaded into R15.
REQ-011 Port: r0 .. r15  output  DATA_W each  current register contents; r0..r15 drive the 16 data inputs of the downstream read-port multiplexer in index order.

Function
REQ-012 The block SHALL hold 16 registers of DATA_W bits each, updated only on the rising clk edge while rst_n is high.
REQ-013 Each output rN SHALL be driven directly from register N with no combinational path from any input; reads are not write-through.
REQ-014 A write SHALL become visible on rN starting the cycle after the capturing clk edge, i.e. 1-cycle write latency.
REQ-015 When we=1 and wa in 0..14, register[wa] SHALL load wd at the clk edge.
REQ-016 When we=1 and wa=15, the general write SHALL be ignored; R15 is owned exclusively by pc_in.
REQ-017 R15 SHALL load pc_in on every rising clk edge, unconditionally.
REQ-018 When bl_we=1, R14 SHALL load lr_data at the clk edge.
REQ-019 When bl_we=1, we=1 and wa=14 in the same cycle, lr_data SHALL win and wd SHALL be discarded.
REQ-020 When bl_we=1, we=1 and wa!=14 (wa<15) in the same cycle, both writes SHALL complete in that cycle.
REQ-021 Registers not addressed in a cycle SHALL retain their value.
REQ-022 X or Z on wa or wd while we=0 SHALL NOT disturb any register state.
REQ-023 The block SHALL contain no read-address logic; register selection is done downstream.

Reset
REQ-024 While rst_n=0, all 16 registers, including R15, SHALL be cleared to 0 immediately, independent of clk.
REQ-025 Reset assertion mid-cycle SHALL override any write pending in that cycle; no write SHALL land on the edge where rst_n is low.
REQ-026 On the first rising clk edge after rst_n deasserts, normal operation SHALL resume: R15 takes pc_in and enabled writes land.

Verification
REQ-027 Reset: drive rst_n=0 between edges with registers preloaded -> r0..r15 read 0 within the same cycle, before any clk edge.
REQ-028 Write/readback: we=1, wa=3, wd=32'hDEADBEEF at edge k -> r3=32'hDEADBEEF from cycle k+1; r3 is unchanged in cycle k; all other rN are unchanged.
REQ-029 R15 protection: pc_in=32'h00000108, we=1, wa=15, wd=32'h12345678 -> r15=32'h00000108 after the edge.
REQ-030 Link collision: bl_we=1, lr_data=32'h00000040, we=1, wa=14, wd=32'hFFFFFFFF -> r14=32'h00000040.
REQ-031 Dual write: bl_we=1, lr_data=32'h0000_0044, we=1, wa=2, wd=32'h0000_0007 -> r14=32'h44 and r2=32'h7 after the same edge.
REQ-032 Reset mid-run: write sequence to R0..R14, then assert rst_n while we=1 -> all outputs 0; after release, the first edge loads only pc_in into R15 and the enabled write.
